// File: rtl/intpol2_d4_decimator_pkg.sv
// intpol2_D4_pkg: shared state encoding, decimation limits and the k clamp
package intpol2_D4_pkg;

    localparam int MAX_LOG2  = 6;
    localparam int CNT_WIDTH = MAX_LOG2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    function automatic logic [2:0] clamp_k(input logic [2:0] d);
        return (d > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : d;
    endfunction

endpackage

// File: rtl/intpol2_d4_decimator_accum.sv
// intpol2_D4_accum: sign-extending group accumulator and sample counter
module intpol2_D4_accum
    import intpol2_D4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = DATA_WIDTH + MAX_LOG2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clr_i,
    input  logic                        en_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    output logic signed [ACC_WIDTH-1:0]  sum_o,
    output logic [CNT_WIDTH-1:0]         cnt_o
);

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]        cnt_q;

    // running sum including the sample on the input, so the top can shift it on the last accept
    always_comb begin
        acc_d = acc_q + {{(ACC_WIDTH-DATA_WIDTH){data_i[DATA_WIDTH-1]}}, data_i};
        sum_o = acc_d;
        cnt_o = cnt_q;
    end

    // clear beats enable so an aborted or finished group leaves no residue
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/intpol2_d4_decimator.sv
// intpol2_d4_decimator: boxcar-average 2^k samples per group and emit one sample
module intpol2_d4_decimator
    import intpol2_D4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int ACC_WIDTH = DATA_WIDTH + MAX_LOG2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clear,
    input  logic                         start,
    input  logic [2:0]                   dec_log2,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         valid_in,
    output logic                         ready_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic                         busy
);

    state_t                      state_q;
    logic [2:0]                  k_q;
    logic [DATA_WIDTH-1:0]       data_q;
    logic                        valid_q;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [CNT_WIDTH-1:0]        cnt;
    logic                        take, last, acc_clr;

    // handshake decodes come only from registered state
    always_comb begin
        take      = (state_q == ACCUM) && valid_in;
        last      = cnt == CNT_WIDTH'((1 << k_q) - 1);
        acc_clr   = clear || ((state_q == IDLE) && start) || ((state_q == OUTPUT) && ready_out);
        ready_in  = state_q == ACCUM;
        busy      = state_q != IDLE;
        valid_out = valid_q;
        data_out  = data_q;
    end

    intpol2_D4_accum #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_accum (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (acc_clr),
        .en_i  (take),
        .data_i(data_in),
        .sum_o (sum),
        .cnt_o (cnt)
    );

    // control FSM with registered output word; the arithmetic shift floors toward -inf
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            k_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            state_q <= IDLE;
            k_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start) begin
                k_q     <= clamp_k(dec_log2);
                state_q <= ACCUM;
            end
        end else if (state_q == ACCUM) begin
            if (take && last) begin
                data_q  <= DATA_WIDTH'(sum >>> k_q);
                valid_q <= 1'b1;
                state_q <= OUTPUT;
            end
        end else if (ready_out) begin
            valid_q <= 1'b0;
            state_q <= ACCUM;
        end
    end

endmodule

// File: tb/tb_intpol2_d4_decimator.sv
// tb_intpol2_d4_decimator: scoreboard bench with directed decimation vectors
module tb_intpol2_d4_decimator;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               clear = 1'b0;
    logic               start = 1'b0;
    logic [2:0]         dec_log2 = '0;
    logic signed [31:0] data_in = '0;
    logic               valid_in = 1'b0;
    logic               ready_in;
    logic signed [31:0] data_out;
    logic               valid_out;
    logic               ready_out = 1'b1;
    logic               busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    intpol2_d4_decimator #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (clear),
        .start    (start),
        .dec_log2 (dec_log2),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops on handshake, checks held data while backpressured
    always @(negedge clk) begin
        if (rstn && valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0d with nothing expected", data_out);
            end else if (ready_out) begin
                chk("out_word", data_out, exp_q.pop_front());
            end else begin
                chk("held_word", data_out, exp_q[0]);
            end
        end
    end

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [31:0] v);
        int n = 0;
        data_in  = v;
        valid_in = 1'b1;
        while (!ready_in && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("send_timeout", 32'(ready_in), 32'd1);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic run(input logic [2:0] d);
        dec_log2 = d;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic restart(input logic [2:0] d);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("idle_after_clear", 32'(busy), 32'd0);
        run(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready_in", 32'(ready_in), 32'd0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        // reset in the middle of a group
        run(3'd2);
        send(32'd1000);
        send(32'd2000);
        rstn = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready_in", 32'(ready_in), 32'd0);
        chk("midrst_valid_out", 32'(valid_out), 32'd0);
        chk("midrst_data_out", data_out, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        // k=2 average, fresh group after reset
        run(3'd2);
        exp_q.push_back(32'd10);
        send(32'd4);
        send(32'd8);
        send(32'd12);
        send(32'd16);
        chk("out_cycle_valid", 32'(valid_out), 32'd1);
        chk("out_cycle_ready_in", 32'(ready_in), 32'd0);
        @(negedge clk);
        chk("valid_one_cycle", 32'(valid_out), 32'd0);
        chk("back_to_accum", 32'(ready_in), 32'd1);
        // floor of -1.5
        restart(3'd1);
        exp_q.push_back(-32'sd2);
        send(-32'sd3);
        send(32'd0);
        // extremes at k=6
        restart(3'd6);
        exp_q.push_back(32'h7FFFFFFF);
        repeat (64) send(32'h7FFFFFFF);
        exp_q.push_back(32'h80000000);
        repeat (64) send(32'h80000000);
        // dec_log2=7 clamps to 6; backpressure with a sample waiting upstream
        restart(3'd7);
        ready_out = 1'b0;
        exp_q.push_back(32'd1);
        repeat (64) send(32'd1);
        exp_q.push_back(32'd2);
        fork
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid", 32'(valid_out), 32'd1);
                    chk("bp_ready_in", 32'(ready_in), 32'd0);
                end
                @(posedge clk);
                #1 ready_out = 1'b1;
            end
            send(32'd65);
        join
        repeat (63) send(32'd1);
        // pass-through
        restart(3'd0);
        exp_q.push_back(32'd5);
        send(32'd5);
        exp_q.push_back(-32'sd7);
        send(-32'sd7);
        // clear on the final accept; start mid-run must be ignored
        restart(3'd2);
        send(32'd1);
        dec_log2 = 3'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(32'd2);
        send(32'd3);
        data_in  = 32'd4;
        valid_in = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        valid_in = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_ready_in", 32'(ready_in), 32'd0);
        chk("clr_valid_out", 32'(valid_out), 32'd0);
        chk("clr_data_out", data_out, 32'd0);
        run(3'd2);
        exp_q.push_back(32'd25);
        send(32'd10);
        send(32'd20);
        send(32'd30);
        send(32'd40);
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
